// File: rtl/life_sequencer.sv
// Sequencer for the cellular-grid datapath: clear, optional LFSR seeding,
// then rate-divided generation ticks with pause/single-step/reseed/limit.
module life_sequencer #(
  parameter int RATE        = 4,
  parameter int SEED_CYCLES = 3,
  parameter int GEN_WIDTH   = 8,
  parameter int MAX_GEN     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 lfsr_load,
  input  logic                 pause,
  input  logic                 step,
  output logic                 grid_rst,
  output logic                 seed_load,
  output logic                 grid_en,
  output logic [GEN_WIDTH-1:0] gen_count,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int SW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [DW-1:0]        DIV_MAX  = DW'(RATE - 1);
  localparam logic [SW-1:0]        SEED_MAX = SW'(SEED_CYCLES - 1);
  localparam logic [GEN_WIDTH-1:0] GEN_LIM  = GEN_WIDTH'(MAX_GEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED, S_RUN, S_PAUSE, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        seed_q, seed_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 en_q, en_d;
  logic                 lfsr_q, step_q;
  logic                 lfsr_rise, step_rise, tick;

  assign lfsr_rise = lfsr_load & ~lfsr_q;
  assign step_rise = step & ~step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      seed_q  <= '0;
      gen_q   <= '0;
      en_q    <= 1'b0;
      lfsr_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      seed_q  <= seed_d;
      gen_q   <= gen_d;
      en_q    <= en_d;
      lfsr_q  <= lfsr_load;
      step_q  <= step;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    seed_d  = seed_q;
    gen_d   = gen_q;
    en_d    = 1'b0;
    tick    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        gen_d   = '0;
        div_d   = '0;
        seed_d  = '0;
        state_d = lfsr_load ? S_SEED : S_RUN;
      end
      S_SEED: begin
        if (seed_q == SEED_MAX) begin
          state_d = S_RUN;
          div_d   = '0;
        end else begin
          seed_d = seed_q + SW'(1);
        end
      end
      S_RUN: begin
        if (lfsr_rise)           state_d = S_CLEAR;
        else if (pause)          state_d = S_PAUSE;
        else if (div_q == DIV_MAX) begin
          div_d = '0;
          tick  = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_PAUSE: begin
        // Divider is frozen here so resuming continues the interrupted interval.
        if (lfsr_rise) state_d = S_CLEAR;
        else begin
          if (step_rise) tick = 1'b1;
          if (!pause)    state_d = S_RUN;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (tick) begin
      en_d  = 1'b1;
      gen_d = gen_q + GEN_WIDTH'(1);
      if (MAX_GEN != 0 && gen_d == GEN_LIM) state_d = S_DONE;
    end

    // Abort has top priority; counters return to zero so IDLE shows all-zero outputs.
    if (state_q != S_IDLE && !start) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      gen_d   = '0;
      div_d   = '0;
      seed_d  = '0;
    end
  end

  assign grid_rst  = (state_q == S_CLEAR);
  assign seed_load = (state_q == S_SEED);
  assign grid_en   = en_q;
  assign gen_count = gen_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench: expected grid_en pulses (cycle, gen_count) are queued at
// stimulus time and popped by per-instance monitors.
module tb_life_sequencer;
  localparam int GW = 8;

  typedef struct { int cyc; int gen; } exp_t;

  logic clk = 1'b0;
  logic reset, start, start1, lfsr_load, pause, step;
  logic grid_rst0, seed_load0, grid_en0, busy0, done0;
  logic grid_rst1, seed_load1, grid_en1, busy1, done1;
  logic [GW-1:0] gen0, gen1;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  life_sequencer #(.RATE(4), .SEED_CYCLES(3), .GEN_WIDTH(GW), .MAX_GEN(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .lfsr_load(lfsr_load),
    .pause(pause), .step(step), .grid_rst(grid_rst0), .seed_load(seed_load0),
    .grid_en(grid_en0), .gen_count(gen0), .busy(busy0), .done(done0)
  );

  life_sequencer #(.RATE(4), .SEED_CYCLES(3), .GEN_WIDTH(GW), .MAX_GEN(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .lfsr_load(lfsr_load),
    .pause(pause), .step(step), .grid_rst(grid_rst1), .seed_load(seed_load1),
    .grid_en(grid_en1), .gen_count(gen1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input int c, input int g);
    exp_t e;
    e.cyc = c; e.gen = g;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input int g);
    exp_t e;
    e.cyc = c; e.gen = g;
    q1.push_back(e);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!reset && grid_en0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0 unexpected grid_en: cycle %0d gen %0d", cyc, gen0);
      end else begin
        e = q0.pop_front();
        chk("dut0 pulse cycle", cyc, e.cyc);
        chk("dut0 pulse gen", gen0, e.gen);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset && grid_en1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1 unexpected grid_en: cycle %0d gen %0d", cyc, gen1);
      end else begin
        e = q1.pop_front();
        chk("dut1 pulse cycle", cyc, e.cyc);
        chk("dut1 pulse gen", gen1, e.gen);
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    lfsr_load = 1'b0; pause = 1'b0; step = 1'b0;
    #1;
    chk("reset grid_en", grid_en0, 0);
    chk("reset gen_count", gen0, 0);
    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset grid_rst", grid_rst0, 0);
    chk("reset seed_load", seed_load0, 0);
    cycles(2);
    reset = 1'b0;
    cycles(1);

    // Plain run, then async reset while a pulse is visible
    c0 = cyc; start = 1'b1;
    push0(c0+6, 1); push0(c0+10, 2); push0(c0+14, 3);
    cycles(1);
    chk("A grid_rst", grid_rst0, 1);
    chk("A busy", busy0, 1);
    cycles(1);
    chk("A grid_rst one cycle", grid_rst0, 0);
    chk("A seed_load", seed_load0, 0);
    cycles(12);
    #1;
    chk("A gen before reset", gen0, 3);
    chk("A grid_en before reset", grid_en0, 1);
    reset = 1'b1;
    #1;
    chk("A async grid_en", grid_en0, 0);
    chk("A async gen_count", gen0, 0);
    chk("A async busy", busy0, 0);
    chk("A async grid_rst", grid_rst0, 0);
    chk("A async seed_load", seed_load0, 0);
    start = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(6);
    chk("A idle after reset", busy0, 0);

    // Seeded run, then reseed at gen 2, then abort coinciding with lfsr rise
    c0 = cyc; start = 1'b1; lfsr_load = 1'b1;
    push0(c0+9, 1); push0(c0+13, 2);
    for (int k = 1; k <= 5; k++) begin
      cycles(1);
      chk("B grid_rst", grid_rst0, (k == 1));
      chk("B seed_load", seed_load0, (k >= 2 && k <= 4));
    end
    cycles(8);
    lfsr_load = 1'b0;
    cycles(1);
    lfsr_load = 1'b1;
    push0(c0+23, 1);
    cycles(1);
    chk("B reseed grid_rst", grid_rst0, 1);
    chk("B reseed gen held in CLEAR", gen0, 2);
    cycles(1);
    chk("B reseed gen cleared", gen0, 0);
    chk("B reseed seed_load", seed_load0, 1);
    cycles(3);
    chk("B reseed seed_load 3 cycles", seed_load0, 0);
    cycles(5);
    lfsr_load = 1'b0;
    cycles(1);
    lfsr_load = 1'b1; start = 1'b0;
    cycles(1);
    chk("B abort grid_rst", grid_rst0, 0);
    chk("B abort busy", busy0, 0);
    chk("B abort gen", gen0, 0);
    lfsr_load = 1'b0;
    cycles(2);

    // Pause at divider 2 with two single steps, then resume
    c0 = cyc; start = 1'b1;
    push0(c0+7, 1); push0(c0+11, 2); push0(c0+17, 3); push0(c0+21, 4);
    cycles(4);
    pause = 1'b1;
    cycles(2);
    step = 1'b1;
    chk("C busy in pause", busy0, 1);
    cycles(1);
    step = 1'b0;
    cycles(3);
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(3);
    chk("C gen after steps", gen0, 2);
    pause = 1'b0;
    cycles(8);
    chk("C gen after resume", gen0, 4);
    start = 1'b0;
    cycles(3);

    // Generation limit on the MAX_GEN=5 instance
    c0 = cyc; start1 = 1'b1;
    for (int k = 1; k <= 5; k++) push1(c0 + 2 + 4*k, k);
    cycles(22);
    chk("E done", done1, 1);
    chk("E busy", busy1, 0);
    chk("E gen", gen1, 5);
    cycles(20);
    chk("E done held", done1, 1);
    chk("E gen held", gen1, 5);
    start1 = 1'b0;
    cycles(2);
    chk("E done cleared", done1, 0);
    chk("E busy idle", busy1, 0);

    chk("dut0 pulses all seen", q0.size(), 0);
    chk("dut1 pulses all seen", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
